// File: rtl/mult_pipe_pkg.sv
// Shared types, defaults and width helper for the mult_pipe pipelined multiplier.
//
// Contents:
//   W_A_DEF/W_B_DEF/STAGES_DEF/ACC_GRD_DEF : default parameter values
//   stage_ctl_t : control part of a stage payload {valid, signed, acc, acc_clr};
//                 the data part is carried next to it with a per-stage width
//   prod_w()    : full-precision product width for two operand widths
//
// Optional accumulator feature: macro MULT_PIPE_ACC_EN (see mult_pipe.sv).
package mult_pipe_pkg;

    localparam int W_A_DEF     = 16;
    localparam int W_B_DEF     = 16;
    localparam int STAGES_DEF  = 3;
    localparam int ACC_GRD_DEF = 8;

    typedef struct packed {
        logic valid;
        logic is_signed;
        logic acc;
        logic acc_clr;
    } stage_ctl_t;

    // Width of an exact product of a w_a-bit and a w_b-bit operand.
    function automatic int prod_w(input int w_a, input int w_b);
        return w_a + w_b;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One payload register slice of the mult_pipe global-stall pipeline.
//
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   en              : pipeline advance; when low the slice holds
//   ctl_in/ctl_out  : control payload (valid, mode, accumulate flags)
//   data_in/data_out: data payload, DW bits
//
// The valid bit follows ctl_in.valid on every advance (bubbles propagate),
// but the rest of the payload is captured only with a valid entry, so a
// bubble never disturbs held data and don't-care inputs never get loaded.
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  stage_ctl_t    ctl_in,
    input  logic [DW-1:0] data_in,
    output stage_ctl_t    ctl_out,
    output logic [DW-1:0] data_out
);

    stage_ctl_t    ctl_q;
    logic [DW-1:0] data_q;

    // Slice register: valid always shifts on advance, payload only with valid data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q  <= '0;
            data_q <= '0;
        end else if (en) begin
            ctl_q.valid <= ctl_in.valid;
            if (ctl_in.valid) begin
                ctl_q.is_signed <= ctl_in.is_signed;
                ctl_q.acc       <= ctl_in.acc;
                ctl_q.acc_clr   <= ctl_in.acc_clr;
                data_q          <= data_in;
            end
        end
    end

    assign ctl_out  = ctl_q;
    assign data_out = data_q;

endmodule

// File: rtl/mult_pipe.sv
// Parametrised pipelined signed/unsigned integer multiplier with a
// valid/ready handshake and a global-stall pipeline of STAGES slices.
//
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready depends only on output side)
//   in_signed            : 1 = two's-complement operands, 0 = unsigned
//   in_a [W_A], in_b [W_B]: operands
//   out_valid / out_ready: output handshake
//   out_y                : exact product, W_A+W_B bits
//                          (W_A+W_B+ACC_GRD bits with MULT_PIPE_ACC_EN)
//   in_acc, in_acc_clr   : accumulate / restart accumulator (MULT_PIPE_ACC_EN only)
//
// Build option: define MULT_PIPE_ACC_EN to add the accumulator at the last stage.
//
// Arithmetic: both operands are extended per mode to P = W_A+W_B bits; the
// product of the extended values modulo 2^P is the exact signed or unsigned
// result. Extended B is split into low and high halves, giving two partial
// products in stage 0 whose sum modulo 2^P is the full product. Middle stages
// carry the partial-product pair; the final add feeds the last stage.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int W_A     = W_A_DEF,
    parameter int W_B     = W_B_DEF,
    parameter int STAGES  = STAGES_DEF,
    parameter int ACC_GRD = ACC_GRD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [W_A-1:0]         in_a,
    input  logic [W_B-1:0]         in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef MULT_PIPE_ACC_EN
    output logic [W_A+W_B+ACC_GRD-1:0] out_y,
    input  logic                   in_acc,
    input  logic                   in_acc_clr
`else
    output logic [W_A+W_B-1:0]     out_y
`endif
);

    localparam int P  = prod_w(W_A, W_B);
    localparam int H  = P / 2;
    localparam int DW = 2 * P;
`ifdef MULT_PIPE_ACC_EN
    localparam int OW = P + ACC_GRD;
`else
    localparam int OW = P;
`endif
    localparam logic [P-1:0] LO_MASK = {{(P-H){1'b0}}, {H{1'b1}}};

    logic          advance;
    logic [P-1:0]  ext_a;
    logic [P-1:0]  ext_b;
    logic [P-1:0]  pp_lo;
    logic [P-1:0]  pp_hi;
    stage_ctl_t    in_ctl;
    logic [DW-1:0] in_data;
    stage_ctl_t    last_ctl_in;
    logic [DW-1:0] last_data_in;
    stage_ctl_t    last_ctl_out;
    logic [P-1:0]  last_prod;
    logic [OW-1:0] y_next;

    // Global stall: the whole pipe moves only when the output slot is free or draining.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Operand extension to the full product width according to the mode bit.
    always_comb begin
        if (in_signed) begin
            ext_a = {{W_B{in_a[W_A-1]}}, in_a};
            ext_b = {{W_A{in_b[W_B-1]}}, in_b};
        end else begin
            ext_a = {{W_B{1'b0}}, in_a};
            ext_b = {{W_A{1'b0}}, in_b};
        end
    end

    // Two partial products; their sum modulo 2^P equals ext_a * ext_b.
    assign pp_lo = ext_a * (ext_b & LO_MASK);
    assign pp_hi = ext_a * (ext_b & ~LO_MASK);

    assign in_ctl.valid     = in_valid & advance;
    assign in_ctl.is_signed = in_signed;
`ifdef MULT_PIPE_ACC_EN
    assign in_ctl.acc       = in_acc;
    assign in_ctl.acc_clr   = in_acc_clr;
`else
    assign in_ctl.acc       = 1'b0;
    assign in_ctl.acc_clr   = 1'b0;
`endif
    assign in_data = {pp_hi, pp_lo};

    generate
        if (STAGES == 1) begin : g_single
            // Single-slice pipe: the full product is formed and registered at once.
            assign last_ctl_in  = in_ctl;
            assign last_data_in = in_data;
        end else begin : g_multi
            stage_ctl_t    mid_ctl  [STAGES-1];
            logic [DW-1:0] mid_data [STAGES-1];
            for (genvar i = 0; i < STAGES - 1; i++) begin : g_mid
                if (i == 0) begin : g_first
                    mult_pipe_stage #(.DW(DW)) u_stage (
                        .clk      (clk),
                        .rst      (rst),
                        .en       (advance),
                        .ctl_in   (in_ctl),
                        .data_in  (in_data),
                        .ctl_out  (mid_ctl[i]),
                        .data_out (mid_data[i])
                    );
                end else begin : g_next
                    mult_pipe_stage #(.DW(DW)) u_stage (
                        .clk      (clk),
                        .rst      (rst),
                        .en       (advance),
                        .ctl_in   (mid_ctl[i-1]),
                        .data_in  (mid_data[i-1]),
                        .ctl_out  (mid_ctl[i]),
                        .data_out (mid_data[i])
                    );
                end
            end
            assign last_ctl_in  = mid_ctl[STAGES-2];
            assign last_data_in = mid_data[STAGES-2];
        end
    endgenerate

    // Final add of the partial-product pair.
    assign last_prod = last_data_in[P-1:0] + last_data_in[DW-1:P];

`ifdef MULT_PIPE_ACC_EN
    logic [OW-1:0] acc;
    logic [OW-1:0] ext_prod;
    logic [OW-1:0] acc_sum;

    // Result selection: restart, accumulate (wrapping) or plain extended product.
    always_comb begin
        if (last_ctl_in.is_signed) begin
            ext_prod = {{ACC_GRD{last_prod[P-1]}}, last_prod};
        end else begin
            ext_prod = {{ACC_GRD{1'b0}}, last_prod};
        end
        acc_sum = acc + ext_prod;
        if (last_ctl_in.acc_clr) begin
            y_next = ext_prod;
        end else if (last_ctl_in.acc) begin
            y_next = acc_sum;
        end else begin
            y_next = ext_prod;
        end
    end

    // Accumulator: updates only when an accumulating transaction enters the last slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (advance && last_ctl_in.valid &&
                     (last_ctl_in.acc || last_ctl_in.acc_clr)) begin
            acc <= y_next;
        end
    end
`else
    localparam int unused_acc_grd = ACC_GRD;
    logic unused_ctl_in;

    // Without the accumulator the last slice just registers the product.
    always_comb begin
        y_next = last_prod;
    end

    assign unused_ctl_in = ^{last_ctl_in.is_signed, last_ctl_in.acc, last_ctl_in.acc_clr};
`endif

    mult_pipe_stage #(.DW(OW)) u_last (
        .clk      (clk),
        .rst      (rst),
        .en       (advance),
        .ctl_in   (last_ctl_in),
        .data_in  (y_next),
        .ctl_out  (last_ctl_out),
        .data_out (out_y)
    );

    logic unused_ctl_out;
    assign unused_ctl_out = ^{last_ctl_out.is_signed, last_ctl_out.acc, last_ctl_out.acc_clr};

    assign out_valid = last_ctl_out.valid;

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: a 16x16 three-stage instance and an
// 8x12 single-stage instance, checked against a plain-arithmetic model.
module tb_mult_pipe;

`ifdef MULT_PIPE_ACC_EN
    localparam int G = 8;
`else
    localparam int G = 0;
`endif
    localparam int Y1 = 32 + G;
    localparam int Y2 = 20 + G;

    logic clk = 1'b0;
    logic rst;

    logic          in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [15:0]   in_a, in_b;
    logic [Y1-1:0] out_y;

    logic          d2_in_valid, d2_in_ready, d2_in_signed, d2_out_valid, d2_out_ready;
    logic [7:0]    d2_in_a;
    logic [11:0]   d2_in_b;
    logic [Y2-1:0] d2_out_y;

`ifdef MULT_PIPE_ACC_EN
    logic        in_acc, in_acc_clr;
    logic        nxt_acc, nxt_clr;
    logic [63:0] acc_m;
`endif

    int tests = 0;
    int fails = 0;
    bit in_fire, out_fire, d2_in_fire, d2_out_fire;
    logic [63:0] exp_q[$];
    logic [63:0] exp2_q[$];

    always #5 clk = ~clk;

    mult_pipe #(.W_A(16), .W_B(16), .STAGES(3), .ACC_GRD(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef MULT_PIPE_ACC_EN
        .out_y(out_y), .in_acc(in_acc), .in_acc_clr(in_acc_clr)
`else
        .out_y(out_y)
`endif
    );

    mult_pipe #(.W_A(8), .W_B(12), .STAGES(1), .ACC_GRD(8)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_signed(d2_in_signed),
        .in_a(d2_in_a), .in_b(d2_in_b),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
`ifdef MULT_PIPE_ACC_EN
        .out_y(d2_out_y), .in_acc(1'b0), .in_acc_clr(1'b0)
`else
        .out_y(d2_out_y)
`endif
    );

    // Exact product of two wa/wb-bit values under the given mode, kept to nbits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int wa, input int wb, input bit sgn,
                                            input int nbits);
        longint av, bv, p;
        logic [63:0] r;
        av = longint'({32'd0, a});
        bv = longint'({32'd0, b});
        if (sgn && a[wa-1]) av = av - (longint'(1) << wa);
        if (sgn && b[wb-1]) bv = bv - (longint'(1) << wb);
        p = av * bv;
        r = p;
        return r & ((64'd1 << nbits) - 64'd1);
    endfunction

    // Drive one cycle on the 16x16 instance and record transfers for the next edge.
    task automatic step1(input bit v, input bit s, input logic [15:0] a,
                         input logic [15:0] b, input bit ordy);
        logic [63:0] e;
        @(negedge clk);
        in_valid  = v;
        in_signed = s;
        in_a      = v ? a : 16'bx;
        in_b      = v ? b : 16'bx;
        out_ready = ordy;
`ifdef MULT_PIPE_ACC_EN
        in_acc     = nxt_acc;
        in_acc_clr = nxt_clr;
`endif
        #1;
        in_fire  = (in_valid === 1'b1) && (in_ready === 1'b1);
        out_fire = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (in_fire) begin
            e = ref_mul({16'd0, a}, {16'd0, b}, 16, 16, s, Y1);
`ifdef MULT_PIPE_ACC_EN
            if (in_acc_clr) begin
                acc_m = e;
            end else if (in_acc) begin
                acc_m = (acc_m + e) & ((64'd1 << Y1) - 64'd1);
                e = acc_m;
            end
`endif
            exp_q.push_back(e);
        end
    endtask

    // Drive one cycle on the 8x12 single-stage instance.
    task automatic step2(input bit v, input bit s, input logic [7:0] a,
                         input logic [11:0] b, input bit ordy);
        @(negedge clk);
        d2_in_valid  = v;
        d2_in_signed = s;
        d2_in_a      = v ? a : 8'bx;
        d2_in_b      = v ? b : 12'bx;
        d2_out_ready = ordy;
        #1;
        d2_in_fire  = (d2_in_valid === 1'b1) && (d2_in_ready === 1'b1);
        d2_out_fire = (d2_out_valid === 1'b1) && (d2_out_ready === 1'b1);
        if (d2_in_fire) exp2_q.push_back(ref_mul({24'd0, a}, {20'd0, b}, 8, 12, s, Y2));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (out_y !== '0) begin fails++; $display("FAIL reset_out_y: got %h want 0", out_y); end
        tests++;
        if (d2_out_valid !== 1'b0) begin fails++; $display("FAIL reset_d2_out_valid: got %b want 0", d2_out_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_unsigned_max();
        int lat;
        logic [Y1-1:0] y_hold;
        step1(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        tests++;
        if (!in_fire) begin fails++; $display("FAIL umax_accept: got 0 want 1"); end
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            step1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            if (out_valid === 1'b1) lat = i;
        end
        tests++;
        if (lat != 3) begin fails++; $display("FAIL umax_latency: got %0d want 3", lat); end
        tests++;
        if (out_y[31:0] !== 32'hFFFE0001) begin fails++; $display("FAIL umax_value: got %h want fffe0001", out_y); end
        if (out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
        y_hold = out_y;
        step1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        tests++;
        if (out_valid !== 1'b0 || out_y !== y_hold) begin
            fails++; $display("FAIL umax_hold_after_drop: got v=%b y=%h want v=0 y=%h", out_valid, out_y, y_hold);
        end
    endtask

    task automatic test_signed();
        logic [31:0] got[2];
        int n = 0;
        step1(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        step1(1'b1, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
        for (int i = 0; i < 10 && n < 2; i++) begin
            step1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            if (out_fire) begin
                tests++;
                if (exp_q.size() == 0 || out_y !== exp_q[0][Y1-1:0]) begin
                    fails++; $display("FAIL signed_model: got %h", out_y);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got[n] = out_y[31:0];
                n++;
            end
        end
        tests++;
        if (n != 2) begin fails++; $display("FAIL signed_count: got %0d want 2", n); end
        else begin
            tests++;
            if (got[0] !== 32'h00000001) begin fails++; $display("FAIL signed_m1xm1: got %h want 00000001", got[0]); end
            tests++;
            if (got[1] !== 32'hC0008000) begin fails++; $display("FAIL signed_minxmax: got %h want c0008000", got[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta[8], tb[8];
        bit ts[8];
        int sent = 0, got = 0, idx;
        bit ordy, prev_stall;
        logic [Y1-1:0] prev_y;
        for (int i = 0; i < 8; i++) begin
            ta[i] = 16'($urandom); tb[i] = 16'($urandom); ts[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 60 && got < 8; c++) begin
            ordy = !(c >= 4 && c < 9);
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_y = out_y;
            idx = (sent < 8) ? sent : 0;
            step1(sent < 8, ts[idx], ta[idx], tb[idx], ordy);
            if (in_fire) sent++;
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_y !== prev_y) begin
                    fails++; $display("FAIL b2b_stall_hold: got v=%b y=%h want v=1 y=%h", out_valid, out_y, prev_y);
                end
            end
            if (out_valid === 1'b1 && !ordy) begin
                tests++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready_stalled: got %b want 0", in_ready); end
            end
            if (out_fire) begin
                tests++;
                if (exp_q.size() == 0 || out_y !== exp_q[0][Y1-1:0]) begin
                    fails++; $display("FAIL b2b_order: got %h (result %0d)", out_y, got);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
            end
        end
        tests++;
        if (got != 8 || exp_q.size() != 0) begin
            fails++; $display("FAIL b2b_count: got %0d results, %0d pending, want 8 and 0", got, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit spurious = 1'b0;
        step1(1'b1, 1'b0, 16'h1234, 16'h0042, 1'b1);
        step1(1'b1, 1'b1, 16'hF000, 16'h0101, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_async: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_y !== '0) begin
            fails++; $display("FAIL rstmid_edge: got v=%b y=%h want v=0 y=0", out_valid, out_y);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
`ifdef MULT_PIPE_ACC_EN
        acc_m = 64'd0;
`endif
        for (int i = 0; i < 6; i++) begin
            step1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            if (out_valid !== 1'b0) spurious = 1'b1;
        end
        tests++;
        if (spurious) begin fails++; $display("FAIL rstmid_no_output: got out_valid=1 want 0"); end
        step1(1'b1, 1'b0, 16'h00FF, 16'h0100, 1'b1);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            step1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            if (out_valid === 1'b1) lat = i;
        end
        tests++;
        if (lat != 3) begin fails++; $display("FAIL rstmid_latency: got %0d want 3", lat); end
        tests++;
        if (out_y !== Y1'(32'h0000FF00)) begin fails++; $display("FAIL rstmid_value: got %h want 0000ff00", out_y); end
        if (out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

`ifdef MULT_PIPE_ACC_EN
    task automatic test_acc();
        logic [15:0] ta[4] = '{16'd3, 16'd5, 16'hFFFF, 16'hFFFE};
        logic [15:0] tb[4] = '{16'd4, 16'd6, 16'hFFFF, 16'd3};
        bit ts[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit ac[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit cl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [39:0] k[4] = '{40'd12, 40'd42, 40'h00FFFE002B, 40'hFFFFFFFFFA};
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            nxt_acc = ac[i]; nxt_clr = cl[i];
            step1(1'b1, ts[i], ta[i], tb[i], 1'b1);
            if (out_fire) begin
                tests++;
                if (out_y !== k[n]) begin fails++; $display("FAIL acc_value%0d: got %h want %h", n, out_y, k[n]); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n++;
            end
        end
        nxt_acc = 1'b0; nxt_clr = 1'b0;
        for (int i = 0; i < 10 && n < 4; i++) begin
            step1(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            if (out_fire) begin
                tests++;
                if (out_y !== k[n]) begin fails++; $display("FAIL acc_value%0d: got %h want %h", n, out_y, k[n]); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n++;
            end
        end
        tests++;
        if (n != 4) begin fails++; $display("FAIL acc_count: got %0d want 4", n); end
    endtask
`endif

    task automatic test_random_stall();
        int sent = 0, got = 0;
        bit pend = 1'b0, s = 1'b0, prev_stall;
        logic [15:0] a = 16'h0000, b = 16'h0000;
        logic [Y1-1:0] prev_y;
        int bad = 0;
        for (int c = 0; c < 4000 && got < 300; c++) begin
            if (!pend && sent < 300) begin
                pend = 1'b1; a = 16'($urandom); b = 16'($urandom); s = 1'($urandom_range(0, 1));
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_y = out_y;
            step1(pend && ($urandom_range(0, 3) != 0), s, a, b, $urandom_range(0, 2) != 0);
            if (in_fire) begin pend = 1'b0; sent++; end
            if (prev_stall && (out_valid !== 1'b1 || out_y !== prev_y)) bad++;
            if (out_fire) begin
                tests++;
                if (exp_q.size() == 0 || out_y !== exp_q[0][Y1-1:0]) begin
                    fails++; $display("FAIL rand3_result%0d: got %h", got, out_y);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
            end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rand3_stall_hold: got %0d violations want 0", bad); end
        tests++;
        if (got != 300 || exp_q.size() != 0) begin
            fails++; $display("FAIL rand3_count: got %0d results, %0d pending, want 300 and 0", got, exp_q.size());
        end
    endtask

    task automatic test_single_stage_random();
        int sent = 0, got = 0, errs = 0;
        bit pend = 1'b0, s = 1'b0;
        logic [7:0] a = 8'h00;
        logic [11:0] b = 12'h000;
        for (int c = 0; c < 40000 && got < 10000; c++) begin
            if (!pend && sent < 10000) begin
                pend = 1'b1; a = 8'($urandom); b = 12'($urandom); s = 1'($urandom_range(0, 1));
            end
            step2(pend && ($urandom_range(0, 3) != 0), s, a, b, $urandom_range(0, 2) != 0);
            if (d2_in_fire) begin pend = 1'b0; sent++; end
            if (d2_out_fire) begin
                tests++;
                if (exp2_q.size() == 0 || d2_out_y !== exp2_q[0][Y2-1:0]) begin
                    fails++; errs++;
                    if (errs <= 10) $display("FAIL s1_result%0d: got %h want %h", got, d2_out_y,
                                             (exp2_q.size() > 0) ? exp2_q[0][Y2-1:0] : '0);
                end
                if (exp2_q.size() > 0) void'(exp2_q.pop_front());
                got++;
            end
        end
        tests++;
        if (got != 10000 || exp2_q.size() != 0) begin
            fails++; $display("FAIL s1_count: got %0d results, %0d pending, want 10000 and 0", got, exp2_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_signed = 1'b0; in_a = 16'h0000; in_b = 16'h0000; out_ready = 1'b1;
        d2_in_valid = 1'b0; d2_in_signed = 1'b0; d2_in_a = 8'h00; d2_in_b = 12'h000; d2_out_ready = 1'b1;
`ifdef MULT_PIPE_ACC_EN
        in_acc = 1'b0; in_acc_clr = 1'b0; nxt_acc = 1'b0; nxt_clr = 1'b0; acc_m = 64'd0;
`endif
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_reset_mid();
`ifdef MULT_PIPE_ACC_EN
        test_acc();
`endif
        test_random_stall();
        test_single_stage_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
